// File: rtl/ws2812_frame_scheduler_pkg.sv
// Shared state encoding and default timing constants for the WS2812 frame scheduler.
package ws_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWAP,
        ST_START,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_LATCH
    } ws_sched_state_t;

    localparam int WS_LATCH_CYCLES_DEF   = 3000;
    localparam int WS_REFRESH_CYCLES_DEF = 500000;
    localparam int WS_ACK_TIMEOUT_DEF    = 255;

endpackage

// File: rtl/ws2812_frame_scheduler_downcounter.sv
// Loadable down-counter that parks at zero; zero flag drives the scheduler's timeouts.
module sched_downcounter #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Decides when to swap the pixel buffer and start a WS2812 transmission, enforcing the latch gap.
// Optional periodic re-send of the front buffer: define WS_SCHED_AUTO_REFRESH_EN.
module ws2812_frame_scheduler
    import ws_sched_pkg::*;
#(
    parameter int LATCH_CYCLES   = WS_LATCH_CYCLES_DEF,
    parameter int REFRESH_CYCLES = WS_REFRESH_CYCLES_DEF,
    parameter int ACK_TIMEOUT    = WS_ACK_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_done,
    input  logic       tx_busy,
    output logic       buf_swap,
    output logic       tx_start,
    output logic       active,
    output logic [7:0] overrun_cnt,
    output logic       ack_err
);

    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    ws_sched_state_t state, state_next;
    logic pending;
    logic latch_zero, ack_zero, refresh_exp;
    logic ack_fail, latch_load;

    assign ack_fail   = (state == ST_WAIT_ACK) && !tx_busy && ack_zero;
    assign latch_load = ack_fail || ((state == ST_WAIT_DONE) && !tx_busy);

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (frame_done || pending)
                    state_next = ST_SWAP;
                else if (refresh_exp)
                    state_next = ST_START;
            end
            ST_SWAP:      state_next = ST_START;
            ST_START:     state_next = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (tx_busy)
                    state_next = ST_WAIT_DONE;
                else if (ack_zero)
                    state_next = ST_LATCH;
            end
            ST_WAIT_DONE: if (!tx_busy) state_next = ST_LATCH;
            ST_LATCH:     if (latch_zero) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Strobes and active are registered decodes of the next state, so they line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            buf_swap <= 1'b0;
            tx_start <= 1'b0;
            active   <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            state    <= state_next;
            buf_swap <= (state_next == ST_SWAP);
            tx_start <= (state_next == ST_START);
            active   <= (state_next != ST_IDLE);
            ack_err  <= ack_err | ack_fail;
        end
    end

    // A frame arriving during SWAP is newer than the one being swapped, so it stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (state == ST_SWAP)
                pending <= frame_done;
            else if (frame_done && state != ST_IDLE)
                pending <= 1'b1;
            if (frame_done && pending && state != ST_SWAP && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

    sched_downcounter #(.W(LW)) u_latch_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (latch_load),
        .load_val (LW'(LATCH_CYCLES - 1)),
        .en       (state == ST_LATCH),
        .zero     (latch_zero)
    );

    sched_downcounter #(.W(AW)) u_ack_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_START),
        .load_val (AW'(ACK_TIMEOUT - 1)),
        .en       (state == ST_WAIT_ACK),
        .zero     (ack_zero)
    );

`ifdef WS_SCHED_AUTO_REFRESH_EN
    localparam int RW = $clog2(REFRESH_CYCLES + 1);

    // Reloads together with every tx_start; comes out of reset with a full period.
    sched_downcounter #(.W(RW), .RST_VAL(RW'(REFRESH_CYCLES - 1))) u_refresh_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_next == ST_START),
        .load_val (RW'(REFRESH_CYCLES - 1)),
        .en       (1'b1),
        .zero     (refresh_exp)
    );
`else
    assign refresh_exp = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Scoreboard bench: stimulus queues expected buf_swap/tx_start cycles, a monitor checks them.
module tb_ws2812_frame_scheduler;

    localparam int L   = 20;
    localparam int ACK = 255;
    localparam int R   = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_done = 1'b0;
    logic       tx_busy = 1'b0;
    logic       buf_swap, tx_start, active, ack_err;
    logic [7:0] overrun_cnt;

    ws2812_frame_scheduler #(
        .LATCH_CYCLES   (L),
        .REFRESH_CYCLES (R),
        .ACK_TIMEOUT    (ACK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_done  (frame_done),
        .tx_busy     (tx_busy),
        .buf_swap    (buf_swap),
        .tx_start    (tx_start),
        .active      (active),
        .overrun_cnt (overrun_cnt),
        .ack_err     (ack_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic kind;   // 0 = buf_swap, 1 = tx_start
        int   cyc;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  n_start = 0;
    int  n_start_exp = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic exp_ev(input logic k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
        if (k) n_start_exp++;
    endtask

    task automatic mon_evt(input logic k);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s: seen at cycle %0d, none expected", k ? "tx_start" : "buf_swap", cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.cyc != cyc) begin
                bad++;
                $display("FAIL event: got %s at %0d want %s at %0d",
                         k ? "tx_start" : "buf_swap", cyc, e.kind ? "tx_start" : "buf_swap", e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (buf_swap === 1'b1) mon_evt(1'b0);
        if (tx_start === 1'b1) begin
            n_start++;
            mon_evt(1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fd();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic wait_start(input int lim, output int t);
        t = -1;
        for (int i = 0; i < lim; i++) begin
            if (tx_start === 1'b1) begin
                t = cyc;
                break;
            end
            tick();
        end
        if (t < 0) begin
            total++;
            bad++;
            $display("FAIL wait_start: no tx_start within %0d cycles (cycle %0d)", lim, cyc);
            t = cyc;
        end
    endtask

    task automatic busy_on();
        repeat (3) tick();
        tx_busy = 1'b1;
    endtask

    task automatic busy_off(output int m);
        tx_busy = 1'b0;
        m = cyc;
    endtask

    initial begin
        int n, t, m, c_rel;

        repeat (3) tick();
        check("rst_buf_swap", buf_swap, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_active", active, 0);
        check("rst_overrun", overrun_cnt, 0);
        check("rst_ack_err", ack_err, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // basic frame: swap N+1, start N+2, active drops L+1 after busy falls
        n = cyc;
        exp_ev(1'b0, n + 1);
        exp_ev(1'b1, n + 2);
        pulse_fd();
        check("basic_active_rise", active, 1);
        wait_start(50, t);
        busy_on();
        repeat (100) tick();
        busy_off(m);
        repeat (L) tick();
        check("basic_active_latch", active, 1);
        tick();
        check("basic_active_fall", active, 0);
        check("basic_gap", cyc - m, L + 1);
        repeat (3) tick();

        // frame_done coincident with SWAP stays pending, no overrun
        n = cyc;
        exp_ev(1'b0, n + 1);
        exp_ev(1'b1, n + 2);
        frame_done = 1'b1;
        tick();
        tick();
        frame_done = 1'b0;
        check("same_cycle_overrun", overrun_cnt, 0);
        wait_start(50, t);
        busy_on();
        repeat (10) tick();
        busy_off(m);
        exp_ev(1'b0, m + L + 2);
        exp_ev(1'b1, m + L + 3);
        wait_start(60, t);
        busy_on();
        repeat (5) tick();
        busy_off(m);
        repeat (L + 5) tick();
        check("same_cycle_overrun_after", overrun_cnt, 0);

        // overrun: two extra frames during one transmission
        n = cyc;
        exp_ev(1'b0, n + 1);
        exp_ev(1'b1, n + 2);
        pulse_fd();
        wait_start(50, t);
        busy_on();
        repeat (10) tick();
        pulse_fd();
        repeat (5) tick();
        pulse_fd();
        repeat (10) tick();
        check("overrun_one", overrun_cnt, 1);
        busy_off(m);
        exp_ev(1'b0, m + L + 2);
        exp_ev(1'b1, m + L + 3);
        wait_start(60, t);
        busy_on();
        repeat (5) tick();
        busy_off(m);
        repeat (L + 5) tick();
        check("overrun_idle", active, 0);

        // saturation of overrun_cnt
        n = cyc;
        exp_ev(1'b0, n + 1);
        exp_ev(1'b1, n + 2);
        pulse_fd();
        wait_start(50, t);
        busy_on();
        repeat (101) pulse_fd();
        check("overrun_101", overrun_cnt, 101);
        repeat (200) pulse_fd();
        check("overrun_sat", overrun_cnt, 255);
        busy_off(m);
        exp_ev(1'b0, m + L + 2);
        exp_ev(1'b1, m + L + 3);
        wait_start(60, t);
        busy_on();
        repeat (5) tick();
        busy_off(m);
        repeat (L + 5) tick();

        // ack timeout: busy never rises
        n = cyc;
        exp_ev(1'b0, n + 1);
        exp_ev(1'b1, n + 2);
        pulse_fd();
        wait_start(50, t);
        repeat (ACK) tick();
        check("ack_err_early", ack_err, 0);
        tick();
        check("ack_err_set", ack_err, 1);
        check("ack_latch_active", active, 1);
        repeat (L) tick();
        check("ack_idle", active, 0);
        repeat (5) tick();
        check("ack_err_sticky", ack_err, 1);

        // asynchronous reset during WAIT_DONE
        n = cyc;
        exp_ev(1'b0, n + 1);
        exp_ev(1'b1, n + 2);
        pulse_fd();
        wait_start(50, t);
        busy_on();
        repeat (10) tick();
        check("pre_rst_active", active, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_active", active, 0);
        check("arst_overrun", overrun_cnt, 0);
        check("arst_ack_err", ack_err, 0);
        check("arst_buf_swap", buf_swap, 0);
        check("arst_tx_start", tx_start, 0);
        tx_busy = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        c_rel = cyc;
        repeat (60) tick();
        check("post_rst_active", active, 0);

`ifdef WS_SCHED_AUTO_REFRESH_EN
        // refresh: tx_start every R cycles, no buf_swap
        exp_ev(1'b1, c_rel + R);
        for (int k = 0; k < 3; k++) begin
            wait_start(R + 100, t);
            if (k < 2) exp_ev(1'b1, t + R);
            busy_on();
            repeat (5) tick();
            busy_off(m);
        end
        repeat (L + 10) tick();
`else
        repeat (1100) tick();
`endif

        check("start_count", n_start, n_start_exp);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
